// File: rtl/ioctl_pacer_pkg.sv
// Shared types for the ioctl download pacer: controller states and the
// FIFO entry layout {index, addr, data}.
package ioctl_pacer_pkg;

    localparam int ADDR_W = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0]        index;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/ioctl_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted when a pop
// happens on the same edge.
module ioctl_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ioctl_pacer.sv
// Buffers ioctl download bytes and replays them to the core's dn_* port on
// ce, holding the core in reset until the FIFO has fully drained.
module ioctl_pacer
    import ioctl_pacer_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int HIGH_WATER = DEPTH - 2
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic [7:0]        dn_index,
    output logic              dn_wr,
    output logic              dn_active,
    output logic              dn_done,
    output logic [24:0]       dn_count,
    output logic [15:0]       dn_sum,
    output logic              dn_overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t         state;
    entry_t         wr_entry;
    entry_t         rd_entry;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  next_count;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push_req;
    logic           push_ok;
    logic           pop;
    logic           drop;
    logic           unused_addr_msb;

    assign unused_addr_msb = ioctl_addr[24];

    assign wr_entry = '{index: ioctl_index, addr: ioctl_addr[ADDR_W-1:0], data: ioctl_dout};

    assign push_req   = (state == LOAD) && ioctl_wr;
    assign pop        = ce && !fifo_empty;
    assign push_ok    = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;
    assign next_count = fifo_count + CW'(push_ok) - CW'(pop);

    ioctl_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_sys),
        .rst_n   (reset_n),
        .push    (push_req),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ioctl_wait  <= 1'b0;
            dn_addr     <= '0;
            dn_data     <= '0;
            dn_index    <= '0;
            dn_wr       <= 1'b0;
            dn_active   <= 1'b0;
            dn_done     <= 1'b0;
            dn_count    <= '0;
            dn_sum      <= '0;
            dn_overflow <= 1'b0;
        end else begin
            dn_wr      <= pop;
            dn_done    <= 1'b0;
            ioctl_wait <= (next_count >= CW'(HIGH_WATER));
            if (pop) begin
                dn_addr  <= rd_entry.addr;
                dn_data  <= rd_entry.data;
                dn_index <= rd_entry.index;
                dn_count <= dn_count + 25'd1;
                dn_sum   <= dn_sum + {8'd0, rd_entry.data};
            end
            if (drop) begin
                dn_overflow <= 1'b1;
            end
            // Counter clears below never coincide with a pop: the FIFO is
            // empty on every edge that starts a new download.
            case (state)
                IDLE: begin
                    if (ioctl_download) begin
                        state       <= LOAD;
                        dn_active   <= 1'b1;
                        dn_count    <= '0;
                        dn_sum      <= '0;
                        dn_overflow <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!ioctl_download) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (fifo_empty && !pop) begin
                        dn_done <= 1'b1;
                        if (ioctl_download) begin
                            state       <= LOAD;
                            dn_count    <= '0;
                            dn_sum      <= '0;
                            dn_overflow <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            dn_active <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ioctl_pacer.sv
// Self-checking bench for ioctl_pacer: table-driven byte vectors plus
// hand-written burst, overflow, flush and reset sequences.
module tb_ioctl_pacer;

    logic        clk_sys;
    logic        reset_n;
    logic        ce;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic [23:0] dn_addr;
    logic [7:0]  dn_data;
    logic [7:0]  dn_index;
    logic        dn_wr;
    logic        dn_active;
    logic        dn_done;
    logic [24:0] dn_count;
    logic [15:0] dn_sum;
    logic        dn_overflow;

    int n_total = 0;
    int n_pass  = 0;
    int done_cnt = 0;
    int ce_period = 0;
    int ce_cnt = 0;
    logic [39:0] exp_q[$];

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic [7:0]  idx;
        logic [23:0] exp_addr;
        logic [24:0] exp_count;
        logic [15:0] exp_sum;
    } vec_t;

    ioctl_pacer #(
        .DEPTH      (8),
        .HIGH_WATER (6)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ce             (ce),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_index       (dn_index),
        .dn_wr          (dn_wr),
        .dn_active      (dn_active),
        .dn_done        (dn_done),
        .dn_count       (dn_count),
        .dn_sum         (dn_sum),
        .dn_overflow    (dn_overflow)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wr_cycle(input logic [24:0] a, input logic [7:0] d, input logic [7:0] i,
                            input bit accept);
        logic [23:0] a24;
        a24 = a[23:0];
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_index = i;
        ioctl_wr    = 1'b1;
        if (accept) exp_q.push_back({i, a24, d});
        step();
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_done(input int max, input logic [24:0] ecount, input logic [15:0] esum,
                             input logic eovf);
        bit got;
        got = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_sys);
            if (dn_done) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", 128'(got), 128'(1));
        check("done_active_low", 128'(dn_active), 128'(0));
        check("done_count", 128'(dn_count), 128'(ecount));
        check("done_sum", 128'(dn_sum), 128'(esum));
        check("done_overflow", 128'(dn_overflow), 128'(eovf));
        check("done_wait_low", 128'(ioctl_wait), 128'(0));
        check("done_all_delivered", 128'(exp_q.size()), 128'(0));
        step();
    endtask

    // ce source: period 0 = off, otherwise one pulse every ce_period cycles
    initial begin
        ce = 1'b0;
        forever begin
            @(negedge clk_sys);
            ce_cnt++;
            ce = (ce_period == 0) ? 1'b0 : ((ce_cnt % ce_period) == 0);
        end
    end

    // Scoreboard consumer: every dn_wr strobe must match the oldest accepted byte
    initial begin
        logic [39:0] e;
        forever begin
            @(negedge clk_sys);
            if (dn_done) done_cnt++;
            if (dn_wr) begin
                if (exp_q.size() == 0) begin
                    check("dn_wr_unexpected", 128'(1), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("dn_wr_entry", 128'({dn_index, dn_addr, dn_data}), 128'(e));
                end
            end
        end
    end

    initial begin
        vec_t vecs[4];
        int   prev_done;

        vecs[0] = '{25'h1ABCDEF, 8'h3C, 8'h01, 24'hABCDEF, 25'd1, 16'h003C};
        vecs[1] = '{25'h0000000, 8'hFF, 8'hFE, 24'h000000, 25'd2, 16'h013B};
        vecs[2] = '{25'h0FFFFFF, 8'h00, 8'h80, 24'hFFFFFF, 25'd3, 16'h013B};
        vecs[3] = '{25'h1000001, 8'h81, 8'h7F, 24'h000001, 25'd4, 16'h01BC};

        reset_n = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        ioctl_index = '0;
        #12;
        check("reset_outputs_a", 128'({ioctl_wait, dn_wr, dn_active, dn_done, dn_overflow}), 128'(0));
        check("reset_outputs_b", 128'({dn_addr, dn_data, dn_index, dn_count, dn_sum}), 128'(0));
        step();
        reset_n = 1'b1;
        step();

        // Single byte, slow drain
        ce_period = 12;
        ioctl_download = 1'b1;
        step();
        check("single_active", 128'(dn_active), 128'(1));
        wr_cycle(25'h10, 8'hA5, 8'h00, 1'b1);
        step();
        ioctl_download = 1'b0;
        wait_done(100, 25'd1, 16'h00A5, 1'b0);
        check("single_addr_hold", 128'({dn_addr, dn_data}), 128'({24'h10, 8'hA5}));

        // Table-driven: one byte at a time, drained every cycle
        ce_period = 1;
        ioctl_download = 1'b1;
        step();
        for (int unsigned k = 0; k < 4; k++) begin
            wr_cycle(vecs[k].addr, vecs[k].data, vecs[k].idx, 1'b1);
            repeat (3) step();
            check("vec_addr", 128'(dn_addr), 128'(vecs[k].exp_addr));
            check("vec_data_idx", 128'({dn_index, dn_data}), 128'({vecs[k].idx, vecs[k].data}));
            check("vec_count", 128'(dn_count), 128'(vecs[k].exp_count));
            check("vec_sum", 128'(dn_sum), 128'(vecs[k].exp_sum));
        end
        ioctl_download = 1'b0;
        wait_done(50, 25'd4, 16'h01BC, 1'b0);

        // Burst of 8 with no drain: wait rises after 6th push
        ce_period = 0;
        ioctl_download = 1'b1;
        step();
        for (int unsigned k = 1; k <= 8; k++) begin
            wr_cycle(25'(k - 1), 8'(k), 8'h02, 1'b1);
            if (k == 5) check("wait_after_5", 128'(ioctl_wait), 128'(0));
            if (k == 6) check("wait_after_6", 128'(ioctl_wait), 128'(1));
        end
        check("burst8_no_overflow", 128'(dn_overflow), 128'(0));
        ce_period = 1;
        ioctl_download = 1'b0;
        wait_done(100, 25'd8, 16'h0024, 1'b0);

        // Burst of 10 with no drain: two bytes dropped
        ce_period = 0;
        ioctl_download = 1'b1;
        step();
        for (int unsigned k = 0; k < 10; k++) begin
            wr_cycle(25'(k), 8'(8'h10 + k), 8'h03, k < 8);
            if (k == 7) check("burst10_no_ovf_at_full", 128'(dn_overflow), 128'(0));
            if (k == 8) check("burst10_ovf_set", 128'(dn_overflow), 128'(1));
        end
        ce_period = 1;
        ioctl_download = 1'b0;
        wait_done(100, 25'd8, 16'h009C, 1'b1);

        // Download drops with 5 queued: active held until the last byte drains
        ce_period = 0;
        ioctl_download = 1'b1;
        step();
        for (int unsigned k = 0; k < 5; k++) wr_cycle(25'(k), 8'(8'h21 + k), 8'h04, 1'b1);
        ioctl_download = 1'b0;
        repeat (3) step();
        check("flush_active_held", 128'(dn_active), 128'(1));
        check("flush_nothing_yet", 128'(dn_count), 128'(0));
        ce_period = 12;
        wait_done(200, 25'd5, 16'h00AF, 1'b0);

        // Full FIFO, push and pop on the same edge
        ce_period = 0;
        ioctl_download = 1'b1;
        step();
        for (int unsigned k = 1; k <= 8; k++) wr_cycle(25'(k), 8'(k), 8'h05, 1'b1);
        check("full_wait_high", 128'(ioctl_wait), 128'(1));
        ce_period = 1;
        wr_cycle(25'd9, 8'h09, 8'h05, 1'b1);
        check("full_pushpop_no_ovf", 128'(dn_overflow), 128'(0));
        ioctl_download = 1'b0;
        wait_done(100, 25'd9, 16'h002D, 1'b0);

        // Reset mid-flush
        ce_period = 0;
        ioctl_download = 1'b1;
        step();
        for (int unsigned k = 0; k < 3; k++) wr_cycle(25'(k), 8'(8'h40 + k), 8'h06, 1'b0);
        ioctl_download = 1'b0;
        repeat (2) step();
        check("pre_reset_active", 128'(dn_active), 128'(1));
        reset_n = 1'b0;
        #2;
        check("midreset_outputs_a", 128'({ioctl_wait, dn_wr, dn_active, dn_done, dn_overflow}), 128'(0));
        check("midreset_outputs_b", 128'({dn_addr, dn_data, dn_index, dn_count, dn_sum}), 128'(0));
        prev_done = done_cnt;
        repeat (2) step();
        reset_n = 1'b1;
        ce_period = 1;
        repeat (20) step();
        check("postreset_no_done", 128'(done_cnt), 128'(prev_done));
        check("postreset_idle", 128'({dn_active, dn_count}), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ioctl_pacer.md
# ioctl_pacer

Rate-adapting buffer between the HPS/sim `ioctl_*` download stream and the `system` core's `dn_*` download port. Captures each `ioctl_wr` byte into a small FIFO and replays it to the core on a clock-enable, so downloads drain at the core's memory rate. Applies `ioctl_wait` back-pressure, holds the core in reset for the whole download including the FIFO flush, and reports byte count, checksum and overflow.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥4.
- `HIGH_WATER`, DEPTH-2: occupancy at or above which `ioctl_wait` asserts.
- `clk_sys`  in  1  system clock (24 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `ce`  in  1  drain enable (e.g. `ce_2`); at most one byte popped per `ce` cycle.
- `ioctl_download`  in  1  download in progress.
- `ioctl_wr`  in  1  one-cycle byte strobe.
- `ioctl_addr`  in  25  byte address; bits [23:0] kept.
- `ioctl_dout`  in  8  byte data.
- `ioctl_index`  in  8  download target index.
- `ioctl_wait`  out  1  back-pressure to source.
- `dn_addr`  out  24  replayed address.
- `dn_data`  out  8  replayed data.
- `dn_index`  out  8  replayed index.
- `dn_wr`  out  1  one-`clk_sys`-cycle write strobe.
- `dn_active`  out  1  core reset request; high through load and flush.
- `dn_done`  out  1  one-cycle pulse at end of flush.
- `dn_count`  out  25  bytes delivered this download.
- `dn_sum`  out  16  modulo-2^16 sum of delivered bytes.
- `dn_overflow`  out  1  sticky: a byte was dropped this download.

## Operation
- States IDLE, LOAD, FLUSH. Reset: IDLE, FIFO empty; every output 0.
- IDLE→LOAD when `ioctl_download`=1; same edge clears `dn_count`, `dn_sum`, `dn_overflow`, sets `dn_active`.
- LOAD→FLUSH when `ioctl_download`=0.
- FLUSH→IDLE when FIFO empty and no pop this cycle; clears `dn_active`, pulses `dn_done`.
- FLUSH with `ioctl_download`=1 at exit: pulse `dn_done`, go to LOAD (counters cleared), `dn_active` stays high.
- Push: in LOAD only, on `ioctl_wr`=1, entry {index, addr[23:0], data}. `ioctl_wr` in IDLE/FLUSH ignored, no overflow.
- Push with FIFO full and no simultaneous pop: byte dropped, `dn_overflow` set.
- Simultaneous push+pop on full FIFO: accepted, occupancy unchanged.
- Pop: on any edge with `ce`=1 and FIFO non-empty (LOAD or FLUSH). Drives `dn_addr/dn_data/dn_index` from entry, `dn_wr`=1 for that one cycle; `dn_count`+=1, `dn_sum`+=data (wraps).
- `dn_addr/dn_data/dn_index` hold last popped values between strobes.

## Timing
- All outputs registered.
- Latency: byte sampled at edge E0 is poppable at E1; if `ce`=1 at E1, `dn_wr` high in cycle after E1 (2 edges minimum).
- `ioctl_wait` = registered (next occupancy ≥ HIGH_WATER); asserts one edge after the push reaching HIGH_WATER; deasserts one edge after the pop dropping below it.
- `dn_done` coincides with the `dn_active` fall (or its would-be fall on re-entry to LOAD).
- `reset_n` low mid-download: FIFO and counters cleared immediately; `dn_active` drops; no `dn_done`.

## Structure
- Package `ioctl_pacer_pkg`: state enum (IDLE/LOAD/FLUSH), entry struct (8+24+8 = 40 bits), `ADDR_W`=24.
- Sub-module `ioctl_fifo`: synchronous FIFO, parameterised width/depth, push/pop/count/full/empty, same-cycle push+pop on full allowed.

## Test plan
- Single byte: download up, wr addr 0x10 data 0xA5 idx 0, `ce` every 12 cycles -> one `dn_wr` with 0x10/0xA5, `dn_count`=1, `dn_sum`=0x00A5, `dn_done` after download drops.
- Burst of 8 bytes 0x01..0x08 on consecutive cycles, DEPTH=8 -> `ioctl_wait` high after 6th push, no overflow, all 8 delivered in order, `dn_sum`=0x0024.
- Burst of 10 ignoring `ioctl_wait`, `ce`=0 -> 2 bytes dropped, `dn_overflow`=1, `dn_count`=8 at done.
- Download drops with 5 bytes queued -> `dn_active` stays high until 5th `dn_wr`, then falls with `dn_done` pulse.
- `ce`=1 every cycle, full FIFO, push+pop same cycle -> byte accepted, no overflow.
- `reset_n` pulsed low mid-flush -> all outputs 0, no `dn_wr`, no `dn_done`.
